// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the hazard sequencer and the pipeline datapath.
// The master side is the datapath: it supplies hazard sources and receives register enables.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [4:0]       id_Rn;
  logic [4:0]       id_Rm;
  logic             id_uses_Rm;
  logic             ex_MemRead;
  logic [4:0]       ex_Rd;
  logic             mem_access;
  logic             br_taken;

  logic             pc_we;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             memwb_bubble;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_Rn, id_Rm, id_uses_Rm, ex_MemRead, ex_Rd, mem_access, br_taken,
    input  pc_we, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
           busy, stall_cycles, flush_count
  );

  modport slave (
    input  id_Rn, id_Rm, id_uses_Rm, ex_MemRead, ex_Rd, mem_access, br_taken,
    output pc_we, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
           busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, branch squash,
// multi-cycle memory freeze, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [0:0]       RUN       = 1'b0;
  localparam logic [0:0]       MEMW      = 1'b1;
  localparam bit               MEM_STALL = (MEM_LAT > 1);
  localparam logic [3:0]       WAIT_INIT = MEM_STALL ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             lu, mem_hit, freeze, flush_apply;

  // XZR reads as zero regardless of in-flight loads, so it never creates a dependency.
  assign lu = hz.ex_MemRead && (hz.ex_Rd != 5'd31) &&
              ((hz.id_Rn == hz.ex_Rd) || (hz.id_uses_Rm && (hz.id_Rm == hz.ex_Rd)));

  // Memory detection is skipped on the release cycle so a held access advances once.
  assign mem_hit = MEM_STALL && hz.mem_access && (state_q == RUN);
  assign freeze  = !rst && (mem_hit || ((state_q == MEMW) && (wait_q != 4'd0)));

  always_comb begin
    // NOTE: every output and next-state variable gets a default first, so no branch can infer a latch.
    hz.pc_we        = 1'b1;
    hz.ifid_en      = 1'b1;
    hz.idex_en      = 1'b1;
    hz.exmem_en     = 1'b1;
    hz.memwb_en     = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_bubble = 1'b0;
    hz.memwb_bubble = 1'b0;
    hz.busy         = !rst && (state_q == MEMW);
    state_d         = state_q;
    wait_d          = wait_q;
    flush_apply     = 1'b0;

    if (freeze) begin
      hz.pc_we        = 1'b0;
      hz.ifid_en      = 1'b0;
      hz.idex_en      = 1'b0;
      hz.exmem_en     = 1'b0;
      hz.memwb_bubble = 1'b1;
      if (mem_hit) begin
        state_d = MEMW;
        wait_d  = WAIT_INIT;
      end else begin
        wait_d = wait_q - 4'd1;
      end
    end else if (!rst) begin
      state_d = RUN;
      if (hz.br_taken) begin
        hz.ifid_flush   = 1'b1;
        hz.idex_bubble  = 1'b1;
        hz.exmem_bubble = 1'b1;
        flush_apply     = 1'b1;
      end else if (lu) begin
        hz.pc_we       = 1'b0;
        hz.ifid_en     = 1'b0;
        hz.idex_bubble = 1'b1;
      end
    end
  end

  assign stall_d = (!hz.pc_we && (stall_q != CNT_MAX)) ? stall_q + CNT_W'(1) : stall_q;
  assign flush_d = (flush_apply && (flush_q != CNT_MAX)) ? flush_q + CNT_W'(1) : flush_q;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: three configurations share randomized stimulus; a reference
// model computes expected enables/counters, a separate monitor compares each cycle.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_Rn, id_Rm, ex_Rd;
  logic       id_uses_Rm, ex_MemRead, mem_access, br_taken;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(4))  if_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_b ();
  pipeline_hazard_ctrl_if #(.CNT_W(8))  if_c ();

  pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4))  dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
  pipeline_hazard_ctrl #(.MEM_LAT(4), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));
  pipeline_hazard_ctrl #(.MEM_LAT(1), .CNT_W(8))  dut_c (.clk(clk), .rst(rst), .hz(if_c.slave));

  assign if_a.id_Rn = id_Rn;           assign if_b.id_Rn = id_Rn;           assign if_c.id_Rn = id_Rn;
  assign if_a.id_Rm = id_Rm;           assign if_b.id_Rm = id_Rm;           assign if_c.id_Rm = id_Rm;
  assign if_a.id_uses_Rm = id_uses_Rm; assign if_b.id_uses_Rm = id_uses_Rm; assign if_c.id_uses_Rm = id_uses_Rm;
  assign if_a.ex_MemRead = ex_MemRead; assign if_b.ex_MemRead = ex_MemRead; assign if_c.ex_MemRead = ex_MemRead;
  assign if_a.ex_Rd = ex_Rd;           assign if_b.ex_Rd = ex_Rd;           assign if_c.ex_Rd = ex_Rd;
  assign if_a.mem_access = mem_access; assign if_b.mem_access = mem_access; assign if_c.mem_access = mem_access;
  assign if_a.br_taken = br_taken;     assign if_b.br_taken = br_taken;     assign if_c.br_taken = br_taken;

  // Control bits packed as {pc_we, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
  // idex_bubble, exmem_bubble, memwb_bubble, busy}.
  logic [9:0]  act_ctl [3];
  logic [31:0] act_st  [3];
  logic [31:0] act_fc  [3];

  assign act_ctl[0] = {if_a.pc_we, if_a.ifid_en, if_a.idex_en, if_a.exmem_en, if_a.memwb_en,
                       if_a.ifid_flush, if_a.idex_bubble, if_a.exmem_bubble, if_a.memwb_bubble, if_a.busy};
  assign act_ctl[1] = {if_b.pc_we, if_b.ifid_en, if_b.idex_en, if_b.exmem_en, if_b.memwb_en,
                       if_b.ifid_flush, if_b.idex_bubble, if_b.exmem_bubble, if_b.memwb_bubble, if_b.busy};
  assign act_ctl[2] = {if_c.pc_we, if_c.ifid_en, if_c.idex_en, if_c.exmem_en, if_c.memwb_en,
                       if_c.ifid_flush, if_c.idex_bubble, if_c.exmem_bubble, if_c.memwb_bubble, if_c.busy};
  assign act_st[0] = 32'(if_a.stall_cycles);
  assign act_st[1] = if_b.stall_cycles;
  assign act_st[2] = 32'(if_c.stall_cycles);
  assign act_fc[0] = 32'(if_a.flush_count);
  assign act_fc[1] = if_b.flush_count;
  assign act_fc[2] = 32'(if_c.flush_count);

  typedef struct packed {
    logic [31:0]       cyc;
    logic [2:0][9:0]   ctl;
    logic [2:0][31:0]  st;
    logic [2:0][31:0]  fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;

  // Reference model state: whether an access is outstanding and how many freeze cycles it has used.
  int              lat [3] = '{3, 4, 1};
  int              cw  [3] = '{4, 32, 8};
  bit              acc [3] = '{0, 0, 0};
  int              frz_done [3] = '{0, 0, 0};
  longint unsigned st  [3] = '{0, 0, 0};
  longint unsigned fc  [3] = '{0, 0, 0};

  task automatic model_step(input int i, output logic [9:0] ctl);
    bit pc, ife, ide, exe, mwe, fl, ib, eb, mb, bz, lu, frz, rel;
    longint unsigned mx;
    pc = 1; ife = 1; ide = 1; exe = 1; mwe = 1; fl = 0; ib = 0; eb = 0; mb = 0; bz = 0;
    frz = 0; rel = 0;
    mx = (64'd1 << cw[i]) - 64'd1;
    lu = ex_MemRead && (ex_Rd != 5'd31) && ((id_Rn == ex_Rd) || (id_uses_Rm && (id_Rm == ex_Rd)));
    if (rst) begin
      acc[i] = 0; frz_done[i] = 0; st[i] = 0; fc[i] = 0;
    end else begin
      if (acc[i]) begin
        bz = 1;
        if (frz_done[i] < lat[i] - 1) frz = 1; else rel = 1;
      end else if (mem_access && lat[i] > 1) begin
        frz = 1; acc[i] = 1; frz_done[i] = 0;
      end
      if (frz) begin
        pc = 0; ife = 0; ide = 0; exe = 0; mb = 1;
        frz_done[i]++;
      end else begin
        if (rel) begin acc[i] = 0; frz_done[i] = 0; end
        if (br_taken) begin fl = 1; ib = 1; eb = 1; end
        else if (lu) begin pc = 0; ife = 0; ib = 1; end
      end
      if (!pc && st[i] != mx) st[i]++;
      if (fl && fc[i] != mx) fc[i]++;
    end
    ctl = {pc, ife, ide, exe, mwe, fl, ib, eb, mb, bz};
  endtask

  task automatic cyc(input bit r, input logic [4:0] rn, input logic [4:0] rm, input bit urm,
                     input bit mr, input logic [4:0] rd, input bit ma, input bit bt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_Rn = rn; id_Rm = rm; id_uses_Rm = urm;
    ex_MemRead = mr; ex_Rd = rd; mem_access = ma; br_taken = bt;
    cycle++;
    e.cyc = 32'(cycle);
    for (int i = 0; i < 3; i++) begin
      logic [9:0] c;
      e.st[i] = st[i][31:0];
      e.fc[i] = fc[i][31:0];
      model_step(i, c);
      e.ctl[i] = c;
    end
    q.push_back(e);
  endtask

  task automatic check(input string name, input int inst, input int cy,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, inst, cy, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          check("ctl", i, int'(e.cyc), 32'(act_ctl[i]), 32'(e.ctl[i]));
          check("stall_cycles", i, int'(e.cyc), act_st[i], e.st[i]);
          check("flush_count", i, int'(e.cyc), act_fc[i], e.fc[i]);
        end
      end
    end
  end

  initial begin : driver
    logic [4:0] rd;
    rst = 1'b1; id_Rn = '0; id_Rm = '0; id_uses_Rm = 0; ex_MemRead = 0; ex_Rd = '0;
    mem_access = 0; br_taken = 0;

    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 1, 0, 0, 0, 0);                 // idle
    cyc(0, 3, 0, 0, 1, 3, 0, 0);                 // load-use on Rn
    cyc(0, 31, 0, 0, 1, 31, 0, 0);               // XZR never stalls
    cyc(0, 4, 5, 0, 1, 5, 0, 0);                 // Rm match, not read
    cyc(0, 4, 5, 1, 1, 5, 0, 0);                 // Rm match, read
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 1, 0);      // held memory access
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 3, 0, 0, 1, 3, 0, 1);                 // branch beats load-use
    repeat (5) cyc(0, 3, 0, 0, 1, 3, 1, 1);      // branch during memory freeze
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);                 // reset mid-wait
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 1, 0);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 2))
        0:       rd = 5'd3;
        1:       rd = 5'd31;
        default: rd = 5'($urandom_range(0, 31));
      endcase
      cyc($urandom_range(0, 59) == 0,
          ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
          $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
    end

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) cyc(0, 7, 0, 0, 1, 7, 0, 0);     // counter saturation
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
